// File: rtl/debug_dump_sequencer.sv
// Streams a full machine-state dump (PC, register file, data-memory window) over the
// UART TX byte handshake, one byte outstanding at a time, MSB byte of each word first.
module debug_dump_sequencer #(
  parameter int NB            = 32,
  parameter int DATA_BITS     = 8,
  parameter int N_REGS        = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int N_MEM_WORDS   = 16,
  parameter int MEM_ADDR_BITS = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [NB-1:0]            i_mips_pc,
  output logic [REG_ADDR_BITS-1:0] o_reg_addr,
  input  logic [NB-1:0]            i_reg_data,
  output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
  input  logic [NB-1:0]            i_mem_data,
  input  logic                     i_uart_tx_done,
  output logic [DATA_BITS-1:0]     o_uart_tx_data,
  output logic                     o_uart_tx_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int BYTES     = NB / DATA_BITS;
  localparam int CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int MAX_WORDS = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE    = CNT_W'(BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_REG_IDX = IDX_W'(N_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM_IDX = IDX_W'(N_MEM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_NEXT
  } state_t;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } phase_t;

  state_t            state_reg;
  phase_t            phase_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [NB-1:0]     shift_reg;
  logic              last_word;
  logic [IDX_W-1:0]  idx_inc;

  assign idx_inc = idx_reg + IDX_W'(1);
  assign o_busy  = (state_reg != ST_IDLE);

  always_comb begin
    last_word = 1'b1;
    case (phase_reg)
      PH_REG:  last_word = (idx_reg == LAST_REG_IDX);
      PH_MEM:  last_word = (idx_reg == LAST_MEM_IDX);
      default: last_word = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= PH_PC;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      shift_reg       <= '0;
      o_uart_tx_data  <= '0;
      o_uart_tx_ready <= 1'b0;
      o_reg_addr      <= '0;
      o_mem_addr      <= '0;
      o_done          <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            state_reg  <= ST_ADDR;
            phase_reg  <= PH_PC;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
          end
        end

        // Addresses were registered on entry; this cycle lets the read data settle.
        ST_ADDR: state_reg <= ST_LATCH;

        ST_LATCH: begin
          case (phase_reg)
            PH_REG:  shift_reg <= i_reg_data;
            PH_MEM:  shift_reg <= i_mem_data;
            default: shift_reg <= i_mips_pc;
          endcase
          state_reg <= ST_SEND;
        end

        ST_SEND: begin
          o_uart_tx_data  <= shift_reg[NB-1 -: DATA_BITS];
          o_uart_tx_ready <= 1'b1;
          state_reg       <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_uart_tx_done) begin
            o_uart_tx_ready <= 1'b0;
            shift_reg       <= shift_reg << DATA_BITS;
            if (cnt_reg == LAST_BYTE) begin
              cnt_reg   <= '0;
              state_reg <= ST_NEXT;
            end else begin
              cnt_reg   <= cnt_reg + CNT_W'(1);
              state_reg <= ST_SEND;
            end
          end
        end

        ST_NEXT: begin
          if (!last_word) begin
            idx_reg    <= idx_inc;
            o_reg_addr <= (phase_reg == PH_REG) ? REG_ADDR_BITS'(idx_inc) : '0;
            o_mem_addr <= (phase_reg == PH_MEM) ? MEM_ADDR_BITS'(idx_inc) : '0;
            state_reg  <= ST_ADDR;
          end else begin
            idx_reg    <= '0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
            case (phase_reg)
              PH_PC: begin
                phase_reg <= PH_REG;
                state_reg <= ST_ADDR;
              end
              PH_REG: begin
                phase_reg <= PH_MEM;
                state_reg <= ST_ADDR;
              end
              default: begin
                phase_reg <= PH_PC;
                state_reg <= ST_IDLE;
                o_done    <= 1'b1;
              end
            endcase
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: full dumps under fixed, random and
// spurious handshake timing, late PC change, busy restarts and mid-dump reset.
module tb_debug_dump_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_mips_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_uart_tx_done;
  logic [7:0]  o_uart_tx_data;
  logic        o_uart_tx_ready;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;

  debug_dump_sequencer dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_mips_pc       (i_mips_pc),
    .o_reg_addr      (o_reg_addr),
    .i_reg_data      (i_reg_data),
    .o_mem_addr      (o_mem_addr),
    .i_mem_data      (i_mem_data),
    .i_uart_tx_done  (i_uart_tx_done),
    .o_uart_tx_data  (o_uart_tx_data),
    .o_uart_tx_ready (o_uart_tx_ready),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational register-file and data-memory models
  assign i_reg_data = 32'h1000_0000 + {27'd0, o_reg_addr};
  assign i_mem_data = 32'hA500_0000 | {27'd0, o_mem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n, input logic [31:0] pc);
    int w;
    int b;
    logic [31:0] val;
    w = n / 4;
    b = n % 4;
    if (w == 0)       val = pc;
    else if (w <= 32) val = 32'h1000_0000 + 32'(w - 1);
    else              val = 32'hA500_0000 | 32'(w - 33);
    return val[31 - 8*b -: 8];
  endfunction

  // mode 0: done 5 cycles after ready. mode 1: PC changed after start, start re-pulsed
  // while busy. mode 2: random done delay 0..40 plus spurious done outside WAIT.
  // abort_word >= 0 returns with ready high on the first byte of that word.
  task automatic run_dump(input int mode, input int abort_word, input logic [31:0] pc_exp);
    int cyc, nbytes, ndone, wait_cnt, delay, low_run, first_rise, word;
    logic ready_prev, acked, finished, aborted;
    logic [7:0] held;
    nbytes = 0; ndone = 0; wait_cnt = 0; delay = 5; low_run = 0; first_rise = -1;
    ready_prev = 1'b0; acked = 1'b0; finished = 1'b0; aborted = 1'b0; held = 8'h00;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 0;
    if (mode == 1) i_mips_pc = pc_exp;
    while (!finished && !aborted && cyc < 20000) begin
      i_uart_tx_done = 1'b0;
      if (acked) begin
        chk("ready_low_after_done", {31'd0, o_uart_tx_ready}, 32'd0);
        acked = 1'b0;
      end else if (ready_prev && !o_uart_tx_ready) begin
        chk("ready_held_until_done", {31'd0, o_uart_tx_ready}, 32'd1);
      end
      if (o_uart_tx_ready) begin
        if (!ready_prev) begin
          if (first_rise < 0) begin
            first_rise = cyc;
            chk("first_ready_latency", cyc, 32'd3);
          end else if (nbytes % 4 == 0) begin
            chk("gap_between_words", low_run, 32'd4);
          end else begin
            chk("gap_within_word", low_run, 32'd1);
          end
          word = nbytes / 4;
          held = o_uart_tx_data;
          $display("byte %0d word %0d data=%02h", nbytes, word, o_uart_tx_data);
          chk("byte_value", {24'd0, o_uart_tx_data}, {24'd0, exp_byte(nbytes, pc_exp)});
          if (nbytes % 4 == 0) begin
            chk("reg_addr", {27'd0, o_reg_addr},
                (word >= 1 && word <= 32) ? 32'(word - 1) : 32'd0);
            chk("mem_addr", {27'd0, o_mem_addr}, (word >= 33) ? 32'(word - 33) : 32'd0);
          end
          if (word == abort_word) begin
            aborted = 1'b1;
          end
          nbytes++;
          wait_cnt = 0;
          delay = (mode == 2) ? int'($urandom_range(0, 40)) : 5;
        end else begin
          chk("data_stable", {24'd0, o_uart_tx_data}, {24'd0, held});
        end
        if (!aborted) begin
          if (wait_cnt == delay) begin
            i_uart_tx_done = 1'b1;
            acked = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
        low_run = 0;
      end else begin
        low_run++;
        if (mode == 2 && $urandom_range(0, 3) == 0) i_uart_tx_done = 1'b1;
      end
      i_start = (mode == 1 && o_busy && $urandom_range(0, 2) == 0);
      if (o_done) begin
        ndone++;
        chk("busy_low_with_done", {31'd0, o_busy}, 32'd0);
        finished = 1'b1;
      end
      ready_prev = o_uart_tx_ready;
      if (!finished && !aborted) begin
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    i_start = 1'b0;
    i_uart_tx_done = 1'b0;
    if (!aborted) begin
      chk("dump_completed", {31'd0, finished}, 32'd1);
      chk("byte_count", nbytes, 32'd196);
      chk("done_pulses", ndone, 32'd1);
      @(posedge i_clk); #1;
      chk("done_single_pulse", {31'd0, o_done}, 32'd0);
      chk("busy_after_dump", {31'd0, o_busy}, 32'd0);
      $display("dump mode %0d: %0d bytes in %0d cycles", mode, nbytes, cyc);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_uart_tx_done = 1'b0; i_mips_pc = 32'h0040_0010;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("reset_ready", {31'd0, o_uart_tx_ready}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    chk("reset_data", {24'd0, o_uart_tx_data}, 32'd0);
    chk("reset_addrs", {22'd0, o_reg_addr, o_mem_addr}, 32'd0);

    // Spurious done while idle must not disturb anything
    i_uart_tx_done = 1'b1;
    @(posedge i_clk); #1;
    i_uart_tx_done = 1'b0;
    chk("idle_done_ignored", {31'd0, o_busy}, 32'd0);

    run_dump(0, -1, 32'h0040_0010);

    i_mips_pc = 32'hDEAD_BEEF;
    run_dump(1, -1, 32'h1234_5678);

    i_mips_pc = 32'h0040_0010;
    run_dump(2, -1, 32'h0040_0010);

    // Reset while waiting on the first byte of REG word 7
    run_dump(0, 8, 32'h0040_0010);
    chk("reg_addr_before_reset", {27'd0, o_reg_addr}, 32'd7);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("abort_ready", {31'd0, o_uart_tx_ready}, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_addrs", {22'd0, o_reg_addr, o_mem_addr}, 32'd0);
    @(posedge i_clk); #1;
    chk("abort_no_resume", {31'd0, o_busy}, 32'd0);

    i_mips_pc = 32'h0000_0ABC;
    run_dump(0, -1, 32'h0000_0ABC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
